shift_rows_pipe: RTL and testbench

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/shift_rows_pipe.sv | 137 +++++++++++++
 tb/tb_shift_rows_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows stage feeding a 2-entry elastic buffer.
// The transform is applied on entry, so the buffer holds finished blocks plus their mode tag.
module shift_rows_pipe #(
    parameter int NB = 4,
    parameter int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [W-1:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic         out_decrypt,
    output logic [15:0]  blk_count
);

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (W != 32 * NB) begin : g_bad_w
            $error("shift_rows_pipe: W must equal 32*NB");
        end
    endgenerate

    // Row r occupies bits [ROW_W*r +: ROW_W]; byte c of that row sits at offset 8*c.
    localparam int ROW_W = 8 * NB;
    localparam int SH2   = (NB == 8) ? 3 : 2;
    localparam int SH3   = (NB == 8) ? 4 : 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic int row_shift(input int r);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return SH2;
            default: return SH3;
        endcase
    endfunction

    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic dec);
        logic [W-1:0] res;
        int           src;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                src = dec ? (c + NB - row_shift(r)) % NB : (c + row_shift(r)) % NB;
                res[ROW_W*r + 8*c +: 8] = d[ROW_W*r + 8*src +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_wptr;
    logic         r_rptr;
    logic         r_in_ready;
    logic [15:0]  r_blk_cnt;
    logic [W-1:0] r_mem_data [2];
    logic         r_mem_dec  [2];
    logic         w_accept;
    logic         w_deliver;
    logic         w_out_valid;
    logic [W-1:0] w_xform;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid && r_in_ready;
    assign w_deliver   = w_out_valid && out_ready;
    assign w_xform     = shift_rows(data_in, in_decrypt);

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_deliver)      w_state_nxt = ST_TWO;
                    else if (!w_accept && w_deliver) w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (w_deliver) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // in_ready is a flop of the next occupancy, so it stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_in_ready <= 1'b0;
            r_blk_cnt  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_deliver) r_blk_cnt <= sat_inc(r_blk_cnt);
            if (flush) begin
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                if (w_accept)  r_wptr <= ~r_wptr;
                if (w_deliver) r_rptr <= ~r_rptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !flush) begin
            r_mem_data[r_wptr] <= w_xform;
            r_mem_dec[r_wptr]  <= in_decrypt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign data_out    = w_out_valid ? r_mem_data[r_rptr] : '0;
    assign out_decrypt = w_out_valid && r_mem_dec[r_rptr];
    assign blk_count   = r_blk_cnt;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: NB=4 instance against a queue model, NB=8 instance against the byte-shift formula.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         flush, in_valid, in_ready, in_decrypt, out_valid, out_ready, out_decrypt;
    logic [127:0] data_in, data_out;
    logic [15:0]  blk_count;

    logic         flush_8, in_valid_8, in_ready_8, in_decrypt_8, out_valid_8, out_ready_8, out_decrypt_8;
    logic [255:0] data_in_8, data_out_8;
    logic [15:0]  blk_count_8;

    shift_rows_pipe #(.NB(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_decrypt(out_decrypt), .blk_count(blk_count)
    );

    shift_rows_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush_8), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .in_decrypt(in_decrypt_8), .data_in(data_in_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .data_out(data_out_8), .out_decrypt(out_decrypt_8), .blk_count(blk_count_8)
    );

    typedef struct { logic [127:0] d; logic dec; } ent_t;
    typedef struct { logic [127:0] din; logic dec; logic [127:0] exp; } vec_t;

    ent_t q[$];
    vec_t tbl[4];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_cnt = 0;
    int   ov_seen = 0;
    bit   rdy_ok = 1'b0;

    // Spec formula: out(r,c) = in(r,(c +/- s_r) mod nb), row-major with 8*nb bits per row.
    function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit dec);
        logic [7:0]   b [4][8];
        int           s [4];
        int           k;
        logic [255:0] o;
        s = '{0, 1, (nb == 8) ? 3 : 2, (nb == 8) ? 4 : 3};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                b[r][c] = d[8*nb*r + 8*c +: 8];
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++) begin
                k = dec ? (c - s[r] + nb) % nb : (c + s[r]) % nb;
                o[8*nb*r + 8*c +: 8] = b[r][k];
            end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock of the NB=4 instance: drive, check against the model, clock, update the model.
    task automatic cycle(input bit v, input logic [127:0] d, input bit dec, input bit ordy, input bit fl);
        bit           m_ready, acc, del;
        ent_t         e;
        logic [255:0] t;
        in_valid = v; data_in = d; in_decrypt = dec; out_ready = ordy; flush = fl;
        #1;
        m_ready = rdy_ok && (q.size() < 2);
        chk("in_ready", 256'(in_ready), 256'(m_ready));
        chk("out_valid", 256'(out_valid), 256'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data_out", 256'(data_out), 256'(q[0].d));
            chk("out_decrypt", 256'(out_decrypt), 256'(q[0].dec));
        end else begin
            chk("data_out_idle", 256'(data_out), 256'(0));
        end
        chk("blk_count", 256'(blk_count), 256'(m_cnt));
        if (out_valid) ov_seen++;
        acc = v && m_ready;
        del = (q.size() != 0) && ordy;
        @(posedge clk);
        rdy_ok = 1'b1;
        if (del && m_cnt < 65535) m_cnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (del) void'(q.pop_front());
            if (acc) begin
                t = ref_shift({128'b0, d}, 4, dec);
                e.d = t[127:0];
                e.dec = dec;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic push8(input logic [255:0] d, input bit dec, input logic [255:0] exp);
        chk("in_ready_8", 256'(in_ready_8), 256'(1));
        in_valid_8 = 1'b1; data_in_8 = d; in_decrypt_8 = dec;
        @(posedge clk);
        #1 in_valid_8 = 1'b0;
        chk("out_valid_8", 256'(out_valid_8), 256'(1));
        chk("data_out_8", data_out_8, exp);
        chk("out_decrypt_8", 256'(out_decrypt_8), 256'(dec));
        @(posedge clk);
        #1 chk("out_valid_8_drained", 256'(out_valid_8), 256'(0));
        @(negedge clk);
    endtask

    logic [127:0] a_blk, b_blk, c_blk;
    logic [255:0] d8, e8;
    int           base;

    initial begin
        tbl[0] = '{din: 128'h0F0E0D0C_0B0A0908_07060504_03020100, dec: 1'b0,
                   exp: 128'h0E0D0C0F_09080B0A_04070605_03020100};
        tbl[1] = '{din: 128'h0F0E0D0C_0B0A0908_07060504_03020100, dec: 1'b1,
                   exp: 128'h0C0F0E0D_09080B0A_06050407_03020100};
        tbl[2] = '{din: 128'h0E0D0C0F_09080B0A_04070605_03020100, dec: 1'b1,
                   exp: 128'h0F0E0D0C_0B0A0908_07060504_03020100};
        tbl[3] = '{din: 128'hFFEEDDCC_BBAA9988_77665544_33221100, dec: 1'b0,
                   exp: 128'hEEDDCCFF_9988BBAA_44776655_33221100};

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b0; data_in = '0;
        flush_8 = 1'b0; in_valid_8 = 1'b0; in_decrypt_8 = 1'b0; out_ready_8 = 1'b1; data_in_8 = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_data_out", 256'(data_out), 256'(0));
        chk("rst_out_decrypt", 256'(out_decrypt), 256'(0));
        chk("rst_blk_count", 256'(blk_count), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First cycle after release: in_ready must still be low.
        cycle(0, '0, 0, 1, 0);

        for (int i = 0; i < 4; i++) begin
            cycle(1, tbl[i].din, tbl[i].dec, 1, 0);
            #1;
            chk("vector_data", 256'(data_out), 256'(tbl[i].exp));
            chk("vector_mode", 256'(out_decrypt), 256'(tbl[i].dec));
        end
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 1, 0);

        // Backpressure: A and B stored, C held off until space frees.
        a_blk = rnd128(); b_blk = rnd128(); c_blk = rnd128();
        base = m_cnt;
        cycle(1, a_blk, 0, 0, 0);
        cycle(1, b_blk, 1, 0, 0);
        #1 chk("full_in_ready", 256'(in_ready), 256'(0));
        cycle(1, c_blk, 0, 0, 0);
        cycle(1, c_blk, 0, 0, 0);
        cycle(1, c_blk, 0, 1, 0);
        cycle(1, c_blk, 0, 1, 0);
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 1, 0);
        #1 chk("abc_blk_count", 256'(blk_count), 256'(base + 3));

        // Sustained stream.
        base = m_cnt;
        ov_seen = 0;
        for (int i = 0; i < 100; i++) cycle(1, rnd128(), ($urandom_range(0, 1) == 1), 1, 0);
        cycle(0, '0, 0, 1, 0);
        chk("stream_valid_cycles", 256'(ov_seen), 256'(100));
        #1 chk("stream_blk_count", 256'(blk_count), 256'(base + 100));

        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 1) == 1), rnd128(), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 1, 0);

        // Flush in TWO with a same-cycle deliver, then flush discarding a same-cycle accept.
        cycle(1, rnd128(), 0, 0, 0);
        cycle(1, rnd128(), 1, 0, 0);
        base = m_cnt;
        cycle(0, '0, 0, 1, 1);
        #1;
        chk("flush_out_valid", 256'(out_valid), 256'(0));
        chk("flush_blk_count", 256'(blk_count), 256'(base + 1));
        cycle(1, rnd128(), 0, 0, 0);
        cycle(1, rnd128(), 0, 0, 1);
        #1 chk("flush_drop_accept", 256'(out_valid), 256'(0));
        cycle(0, '0, 0, 1, 0);

        // Reset with the buffer full.
        cycle(1, rnd128(), 0, 0, 0);
        cycle(1, rnd128(), 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_data_out", 256'(data_out), 256'(0));
        chk("mid_rst_blk_count", 256'(blk_count), 256'(0));
        chk("mid_rst_in_ready", 256'(in_ready), 256'(0));
        q.delete(); m_cnt = 0; rdy_ok = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, rnd128(), 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(1, rnd128(), ($urandom_range(0, 1) == 1), 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 1, 0);

        // NB=8 instance.
        d8 = 256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
        e8 = 256'h1B1A19181F1E1D1C_1211101716151413_080F0E0D0C0B0A09_0706050403020100;
        push8(d8, 0, e8);
        push8(e8, 1, d8);
        for (int i = 0; i < 6; i++) begin
            d8 = {rnd128(), rnd128()};
            push8(d8, (i % 2 == 1), ref_shift(d8, 8, (i % 2 == 1)));
        end
        chk("blk_count_8", 256'(blk_count_8), 256'(8));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
